// File: rtl/calc_ctrl.sv
// Keypad calculator controller: turns scanner key events into two-operand add/subtract with saturation.
// One cycle from key event to registered outputs, no backpressure (one event per two cycles); CALC_BCD_OUT_EN adds a BCD display converter.
module calc_ctrl #(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_pressed,
    input  logic             is_number,
    input  logic             is_op,
    input  logic             is_eq,
    input  logic [3:0]       num_val,
    input  logic [1:0]       op_val,
    output logic [WIDTH-1:0] disp_val,
    output logic [1:0]       state,
    output logic             result_valid,
    output logic             ovf,
    output logic             entry_full
`ifdef CALC_BCD_OUT_EN
    ,
    output logic [4*(DIGITS+1)-1:0] bcd,
    output logic                    bcd_neg,
    output logic                    bcd_valid
`endif
);

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_OP  = 2'd1,
        S_B   = 2'd2,
        S_RES = 2'd3
    } state_t;

    localparam int CW = $clog2(DIGITS + 1);
    localparam logic signed [WIDTH:0] MAX_V = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH:0] MIN_V = {2'b11, {(WIDTH-1){1'b0}}};

    state_t                  st_q, st_n;
    logic signed [WIDTH-1:0] a_q, b_q, r_q, a_n, b_n, r_n;
    logic                    op_q, op_n;
    logic [CW-1:0]           cnt_q, cnt_n;
    logic                    ovf_n, rv_n, full_n;
    logic [WIDTH-1:0]        disp_n;
    logic                    prev_q, ready_q;

    logic                    evt, dig_evt, op_evt, eq_evt, has_room, new_op;
    logic signed [WIDTH-1:0] d_ext, a_app, b_app, sat_val;
    logic signed [WIDTH:0]   a_x, b_x, sum;
    logic                    sat_hi, sat_lo;

    // ready_q holds off events until the first edge after reset has passed
    assign evt     = btn_pressed & ~prev_q & ready_q;
    assign dig_evt = evt & is_number & (num_val <= 4'd9);
    assign op_evt  = evt & ~is_number & is_op & ((op_val == 2'd1) || (op_val == 2'd2));
    assign eq_evt  = evt & ~is_number & ~is_op & is_eq;
    assign new_op  = (op_val == 2'd2);

    assign has_room = (cnt_q < CW'(DIGITS));
    assign d_ext    = {{(WIDTH-4){1'b0}}, num_val};
    assign a_app    = (a_q <<< 3) + (a_q <<< 1) + d_ext;
    assign b_app    = (b_q <<< 3) + (b_q <<< 1) + d_ext;

    assign a_x     = {a_q[WIDTH-1], a_q};
    assign b_x     = {b_q[WIDTH-1], b_q};
    assign sum     = op_q ? (a_x - b_x) : (a_x + b_x);
    assign sat_hi  = (sum > MAX_V);
    assign sat_lo  = (sum < MIN_V);
    assign sat_val = sat_hi ? MAX_V[WIDTH-1:0] : (sat_lo ? MIN_V[WIDTH-1:0] : sum[WIDTH-1:0]);

    always_comb begin
        st_n  = st_q;
        a_n   = a_q;
        b_n   = b_q;
        r_n   = r_q;
        op_n  = op_q;
        cnt_n = cnt_q;
        ovf_n = ovf;
        rv_n  = 1'b0;
        case (st_q)
            S_A: begin
                if (dig_evt && has_room) begin
                    a_n   = a_app;
                    cnt_n = cnt_q + CW'(1);
                end else if (op_evt) begin
                    op_n  = new_op;
                    cnt_n = '0;
                    st_n  = S_OP;
                end
            end
            S_OP: begin
                if (dig_evt) begin
                    b_n   = d_ext;
                    cnt_n = CW'(1);
                    st_n  = S_B;
                end else if (op_evt) begin
                    op_n = new_op;
                end
            end
            S_B: begin
                if (dig_evt && has_room) begin
                    b_n   = b_app;
                    cnt_n = cnt_q + CW'(1);
                end else if (op_evt) begin
                    a_n   = sat_val;
                    ovf_n = ovf | sat_hi | sat_lo;
                    op_n  = new_op;
                    cnt_n = '0;
                    st_n  = S_OP;
                end else if (eq_evt) begin
                    r_n   = sat_val;
                    ovf_n = ovf | sat_hi | sat_lo;
                    rv_n  = 1'b1;
                    cnt_n = '0;
                    st_n  = S_RES;
                end
            end
            S_RES: begin
                if (dig_evt) begin
                    a_n   = d_ext;
                    cnt_n = CW'(1);
                    ovf_n = 1'b0;
                    st_n  = S_A;
                end else if (op_evt) begin
                    a_n   = r_q;
                    op_n  = new_op;
                    cnt_n = '0;
                    st_n  = S_OP;
                end
            end
            default: st_n = S_A;
        endcase

        case (st_n)
            S_B:     disp_n = b_n;
            S_RES:   disp_n = r_n;
            default: disp_n = a_n;
        endcase
        full_n = ((st_n == S_A) || (st_n == S_B)) && (cnt_n == CW'(DIGITS));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q         <= S_A;
            a_q          <= '0;
            b_q          <= '0;
            r_q          <= '0;
            op_q         <= 1'b0;
            cnt_q        <= '0;
            prev_q       <= 1'b0;
            ready_q      <= 1'b0;
            disp_val     <= '0;
            result_valid <= 1'b0;
            ovf          <= 1'b0;
            entry_full   <= 1'b0;
        end else begin
            st_q         <= st_n;
            a_q          <= a_n;
            b_q          <= b_n;
            r_q          <= r_n;
            op_q         <= op_n;
            cnt_q        <= cnt_n;
            prev_q       <= btn_pressed;
            ready_q      <= 1'b1;
            disp_val     <= disp_n;
            result_valid <= rv_n;
            ovf          <= ovf_n;
            entry_full   <= full_n;
        end
    end

    assign state = st_q;

`ifdef CALC_BCD_OUT_EN
    localparam int BW  = 4 * (DIGITS + 1);
    localparam int SCW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] disp_last, bin_q, mag;
    logic [BW-1:0]    acc_q, adj;
    logic [SCW-1:0]   sh_cnt;
    logic             busy, neg_q;

    assign mag = disp_val[WIDTH-1] ? (~disp_val + WIDTH'(1)) : disp_val;

    always_comb begin
        adj = acc_q;
        for (int i = 0; i < DIGITS + 1; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
    end

    // A display change always wins, restarting any conversion in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_last <= '0;
            bin_q     <= '0;
            acc_q     <= '0;
            sh_cnt    <= '0;
            busy      <= 1'b0;
            neg_q     <= 1'b0;
            bcd       <= '0;
            bcd_neg   <= 1'b0;
            bcd_valid <= 1'b1;
        end else if (disp_val != disp_last) begin
            disp_last <= disp_val;
            bin_q     <= mag;
            neg_q     <= disp_val[WIDTH-1];
            acc_q     <= '0;
            sh_cnt    <= SCW'(WIDTH);
            busy      <= 1'b1;
            bcd_valid <= 1'b0;
        end else if (busy) begin
            if (sh_cnt != '0) begin
                acc_q  <= {adj[BW-2:0], bin_q[WIDTH-1]};
                bin_q  <= bin_q << 1;
                sh_cnt <= sh_cnt - SCW'(1);
            end else begin
                bcd       <= acc_q;
                bcd_neg   <= neg_q;
                bcd_valid <= 1'b1;
                busy      <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_calc_ctrl.sv
// Bench for calc_ctrl: directed vector table, hand-written corner sequences and random keys against a reference model.
module tb_calc_ctrl;
    localparam int DIGITS = 4;
    localparam int WIDTH  = 16;
    localparam int MAXV   = 2 ** (WIDTH - 1) - 1;
    localparam int MINV   = -(2 ** (WIDTH - 1));
    localparam int K_DIG = 0, K_OP = 1, K_EQ = 2, K_NONE = 3;
    localparam int ADD = 1, SUB = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             btn_pressed = 1'b0;
    logic             is_number = 1'b0, is_op = 1'b0, is_eq = 1'b0;
    logic [3:0]       num_val = '0;
    logic [1:0]       op_val = '0;
    logic [WIDTH-1:0] disp_val;
    logic [1:0]       state;
    logic             result_valid, ovf, entry_full;
`ifdef CALC_BCD_OUT_EN
    logic [4*(DIGITS+1)-1:0] bcd;
    logic                    bcd_neg, bcd_valid;
`endif

    calc_ctrl #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .btn_pressed(btn_pressed),
        .is_number(is_number), .is_op(is_op), .is_eq(is_eq),
        .num_val(num_val), .op_val(op_val),
        .disp_val(disp_val), .state(state), .result_valid(result_valid),
        .ovf(ovf), .entry_full(entry_full)
`ifdef CALC_BCD_OUT_EN
        , .bcd(bcd), .bcd_neg(bcd_neg), .bcd_valid(bcd_valid)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int nerr = 0, nchk = 0;
    logic rv1, rv2;

    typedef struct {
        int kind; int val; int disp; int st; int ovf; int full; int rv;
    } vec_t;
    vec_t vq[$];

    function automatic void add_v(int k, int v, int d, int s, int o, int f, int rv);
        vec_t e;
        e.kind = k; e.val = v; e.disp = d; e.st = s; e.ovf = o; e.full = f; e.rv = rv;
        vq.push_back(e);
    endfunction

    function automatic void add_9s(int s, int o);
        add_v(K_DIG, 9, 9, s, o, 0, 0);
        add_v(K_DIG, 9, 99, s, o, 0, 0);
        add_v(K_DIG, 9, 999, s, o, 0, 0);
        add_v(K_DIG, 9, 9999, s, o, 1, 0);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int d, input int s, input int o,
                              input int f, input int rv);
        chk({tag, " disp_val"}, int'($signed(disp_val)), d);
        chk({tag, " state"}, int'(state), s);
        chk({tag, " ovf"}, int'(ovf), o);
        chk({tag, " entry_full"}, int'(entry_full), f);
        chk({tag, " result_valid pulse"}, int'(rv1), rv);
        chk({tag, " result_valid after"}, int'(rv2), 0);
    endtask

    // One key event: rv1 is sampled in the cycle after the event, rv2 one cycle later
    task automatic press(input int kind, input int val, input int hold);
        @(negedge clk);
        is_number   = (kind == K_DIG);
        is_op       = (kind == K_OP);
        is_eq       = (kind == K_EQ);
        num_val     = (kind == K_DIG) ? 4'(val) : 4'($urandom_range(0, 15));
        op_val      = (kind == K_OP) ? 2'(val) : 2'($urandom_range(0, 3));
        btn_pressed = 1'b1;
        @(negedge clk);
        rv1 = result_valid;
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            if (i == 1) rv2 = result_valid;
        end
        btn_pressed = 1'b0;
        is_number = 1'b0; is_op = 1'b0; is_eq = 1'b0;
        @(negedge clk);
        if (hold == 1) rv2 = result_valid;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Reference model: operands kept as plain integers, clamping done by comparison
    int m_st, m_a, m_b, m_r, m_sub, m_cnt, m_ovf, m_rv;

    function automatic int m_sat(int x);
        if (x > MAXV) begin m_ovf = 1; return MAXV; end
        if (x < MINV) begin m_ovf = 1; return MINV; end
        return x;
    endfunction

    function automatic int m_calc();
        return m_sat(m_sub ? (m_a - m_b) : (m_a + m_b));
    endfunction

    function automatic void m_reset();
        m_st = 0; m_a = 0; m_b = 0; m_r = 0; m_sub = 0; m_cnt = 0; m_ovf = 0; m_rv = 0;
    endfunction

    function automatic void m_key(int kind, int val);
        m_rv = 0;
        if (kind == K_DIG && val <= 9) begin
            if (m_st == 0 && m_cnt < DIGITS) begin m_a = m_a * 10 + val; m_cnt++; end
            else if (m_st == 1) begin m_b = val; m_cnt = 1; m_st = 2; end
            else if (m_st == 2 && m_cnt < DIGITS) begin m_b = m_b * 10 + val; m_cnt++; end
            else if (m_st == 3) begin m_a = val; m_cnt = 1; m_ovf = 0; m_st = 0; end
        end else if (kind == K_OP && (val == ADD || val == SUB)) begin
            if (m_st == 2) m_a = m_calc();
            else if (m_st == 3) m_a = m_r;
            m_sub = (val == SUB);
            m_st = 1;
        end else if (kind == K_EQ && m_st == 2) begin
            m_r = m_calc();
            m_rv = 1;
            m_st = 3;
        end
    endfunction

    function automatic int m_disp();
        return (m_st == 2) ? m_b : ((m_st == 3) ? m_r : m_a);
    endfunction

    function automatic int m_full();
        return ((m_st == 0 || m_st == 2) && m_cnt == DIGITS) ? 1 : 0;
    endfunction

    initial begin
        // Directed table: each row is one key and the outputs expected after it
        add_v(K_DIG, 1, 1, 0, 0, 0, 0);
        add_v(K_DIG, 2, 12, 0, 0, 0, 0);
        add_v(K_OP, ADD, 12, 1, 0, 0, 0);
        add_v(K_DIG, 3, 3, 2, 0, 0, 0);
        add_v(K_DIG, 4, 34, 2, 0, 0, 0);
        add_v(K_EQ, 0, 46, 3, 0, 0, 1);
        add_v(K_DIG, 5, 5, 0, 0, 0, 0);
        add_v(K_OP, SUB, 5, 1, 0, 0, 0);
        add_v(K_DIG, 9, 9, 2, 0, 0, 0);
        add_v(K_EQ, 0, -4, 3, 0, 0, 1);
        add_v(K_EQ, 0, -4, 3, 0, 0, 0);
        add_v(K_DIG, 1, 1, 0, 0, 0, 0);
        add_v(K_DIG, 2, 12, 0, 0, 0, 0);
        add_v(K_DIG, 3, 123, 0, 0, 0, 0);
        add_v(K_DIG, 4, 1234, 0, 0, 1, 0);
        add_v(K_DIG, 5, 1234, 0, 0, 1, 0);
        add_v(K_DIG, 12, 1234, 0, 0, 1, 0);
        add_v(K_NONE, 0, 1234, 0, 0, 1, 0);
        add_v(K_OP, ADD, 1234, 1, 0, 0, 0);
        add_v(K_EQ, 0, 1234, 1, 0, 0, 0);
        add_v(K_OP, 3, 1234, 1, 0, 0, 0);
        add_v(K_OP, 0, 1234, 1, 0, 0, 0);
        add_v(K_OP, SUB, 1234, 1, 0, 0, 0);
        add_9s(2, 0);
        add_v(K_EQ, 0, -8765, 3, 0, 0, 1);
        add_9s(0, 0);
        add_v(K_OP, ADD, 9999, 1, 0, 0, 0);
        add_9s(2, 0);
        add_v(K_OP, ADD, 19998, 1, 0, 0, 0);
        add_9s(2, 0);
        add_v(K_OP, ADD, 29997, 1, 0, 0, 0);
        add_9s(2, 0);
        add_v(K_EQ, 0, 32767, 3, 1, 0, 1);
        add_v(K_DIG, 7, 7, 0, 0, 0, 0);
        add_v(K_OP, ADD, 7, 1, 0, 0, 0);
        add_v(K_DIG, 3, 3, 2, 0, 0, 0);
        add_v(K_EQ, 0, 10, 3, 0, 0, 1);
        add_v(K_OP, SUB, 10, 1, 0, 0, 0);
        add_v(K_DIG, 5, 5, 2, 0, 0, 0);
        add_v(K_OP, ADD, 5, 1, 0, 0, 0);
        add_v(K_EQ, 0, 5, 1, 0, 0, 0);
        add_v(K_OP, SUB, 5, 1, 0, 0, 0);
        add_9s(2, 0);
        add_v(K_OP, SUB, -9994, 1, 0, 0, 0);
        add_9s(2, 0);
        add_v(K_OP, SUB, -19993, 1, 0, 0, 0);
        add_9s(2, 0);
        add_v(K_OP, SUB, -29992, 1, 0, 0, 0);
        add_9s(2, 0);
        add_v(K_EQ, 0, -32768, 3, 1, 0, 1);
        add_v(K_OP, ADD, -32768, 1, 1, 0, 0);
        add_v(K_DIG, 1, 1, 2, 1, 0, 0);
        add_v(K_EQ, 0, -32767, 3, 1, 0, 1);
        add_v(K_DIG, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("reset disp_val", int'(disp_val), 0);
        chk("reset state", int'(state), 0);
        chk("reset result_valid", int'(result_valid), 0);
        chk("reset ovf", int'(ovf), 0);
        chk("reset entry_full", int'(entry_full), 0);
`ifdef CALC_BCD_OUT_EN
        chk("reset bcd", int'(bcd), 0);
        chk("reset bcd_neg", int'(bcd_neg), 0);
        chk("reset bcd_valid", int'(bcd_valid), 1);
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vq[i]) begin
            press(vq[i].kind, vq[i].val, 1);
            check_outs($sformatf("vec%0d", i), vq[i].disp, vq[i].st, vq[i].ovf, vq[i].full, vq[i].rv);
        end

        // Held key must append exactly once; invalid operator is a no-op
        do_reset();
        press(K_DIG, 8, 1000);
        check_outs("held key", 8, 0, 0, 0, 0);
        press(K_OP, 3, 1);
        check_outs("op_val 3", 8, 0, 0, 0, 0);

        // Asynchronous reset in the middle of an entry
        do_reset();
        press(K_DIG, 4, 1);
        press(K_OP, ADD, 2);
        press(K_DIG, 6, 1);
        check_outs("pre-reset", 6, 2, 0, 0, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async reset disp_val", int'(disp_val), 0);
        chk("async reset state", int'(state), 0);
        chk("async reset ovf", int'(ovf), 0);
        chk("async reset entry_full", int'(entry_full), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        press(K_DIG, 2, 1);
        check_outs("post-reset key", 2, 0, 0, 0, 0);

`ifdef CALC_BCD_OUT_EN
        begin
            int k;
            do_reset();
            press(K_DIG, 5, 1);
            press(K_OP, SUB, 1);
            press(K_DIG, 9, 1);
            repeat (30) @(negedge clk);
            is_eq = 1'b1;
            btn_pressed = 1'b1;
            @(negedge clk);
            btn_pressed = 1'b0;
            is_eq = 1'b0;
            chk("bcd disp_val", int'($signed(disp_val)), -4);
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!bcd_valid && k < 100);
            chk("bcd latency", k, WIDTH + 2);
            chk("bcd value", int'(bcd), 4);
            chk("bcd_neg", int'(bcd_neg), 1);
        end
`endif

        // Random keys against the reference model
        do_reset();
        m_reset();
        for (int i = 0; i < 400; i++) begin
            int r, kind, val;
            r = $urandom_range(0, 99);
            if (r < 45) begin
                kind = K_DIG;
                val = (r < 3) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            end else if (r < 75) begin
                kind = K_OP;
                val = (r >= 72) ? 3 * $urandom_range(0, 1) : $urandom_range(1, 2);
            end else if (r < 95) begin
                kind = K_EQ; val = 0;
            end else begin
                kind = K_NONE; val = 0;
            end
            press(kind, val, $urandom_range(1, 3));
            m_key(kind, val);
            check_outs($sformatf("rnd%0d", i), m_disp(), m_st, m_ovf, m_full(), m_rv);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Key-event consumer for the keypad calculator. It sits directly downstream of the keypad scanner and takes its decoded key stream (is_number / is_op / is_eq / num_val / op_val, qualified by btn_pressed). It accumulates two decimal operands, applies add or subtract, and drives a signed display value plus status flags. This is the receiving end of the scanner's key-event interface.

## Interface
Parameters:
- DIGITS, 4, max decimal digits per operand; constraint 10^DIGITS ≤ 2^(WIDTH-1)
- WIDTH, 16, two's-complement width of operands, result and display

Ports:
- clk  input  1  system clock; single clock domain
- reset  input  1  asynchronous, active-high; all state cleared immediately
- btn_pressed  input  1  key-held level from scanner
- is_number  input  1  key class: digit
- is_op  input  1  key class: operator
- is_eq  input  1  key class: equals
- num_val  input  4  digit value 0-9
- op_val  input  2  1 = add, 2 = subtract; 0 and 3 invalid
- disp_val  output  WIDTH  signed value to display
- state  output  2  0 = S_A, 1 = S_OP, 2 = S_B, 3 = S_RES
- result_valid  output  1  one-cycle pulse when an equals completes
- ovf  output  1  saturation occurred; sticky
- entry_full  output  1  current operand holds DIGITS digits

## Operation
- Event detection: event = btn_pressed high in this cycle and low in the previous cycle (prev flag reset to 0). Class and value inputs are sampled in the event cycle. A held key produces exactly one event.
- Event with no class bit set, with num_val > 9, or with op_val ∈ {0,3}: ignored entirely.
- Registers: A, B (signed WIDTH), op (1 bit), cnt (digit count 0..DIGITS), R (result).
- S_A:
  - Digit: if cnt < DIGITS then A ← A·10 + d and cnt++; otherwise ignored.
  - Op: latch op, move to S_OP.
  - Eq: ignored.
- S_OP:
  - Digit: B ← d, cnt ← 1, move to S_B.
  - Op: replace the latched op.
  - Eq: ignored.
- S_B:
  - Digit: append to B under the same cnt rule.
  - Op (chain): A ← sat(A op B), latch the new op, move to S_OP.
  - Eq: R ← sat(A op B), pulse result_valid, move to S_RES.
- S_RES:
  - Digit: A ← d, cnt ← 1, ovf ← 0, move to S_A.
  - Op: A ← R, latch op, move to S_OP.
  - Eq: ignored (no pulse).
- Arithmetic:
  - Computed at WIDTH+1 bits.
  - sat() clamps to [−2^(WIDTH-1), 2^(WIDTH-1)−1] and sets ovf when clamping occurs.
  - ovf clears only on a digit event in S_RES or on reset.
- disp_val source by state: S_A → A, S_OP → A, S_B → B, S_RES → R.
- entry_full = (cnt == DIGITS) in S_A or S_B; 0 otherwise.
- Reset values: state S_A, A = B = R = 0, cnt = 0, op = add, disp_val = 0, result_valid = 0, ovf = 0, entry_full = 0.

## Timing
- All outputs are registered.
- Event in cycle n: state, registers, disp_val, ovf and entry_full update at the edge ending cycle n and are visible in cycle n+1.
- result_valid is high for cycle n+1 only.
- Back-to-back events are impossible by construction: btn_pressed must fall before the next event. The block tolerates events on every second cycle.
- Reset assertion mid-entry or mid-chain discards all operands asynchronously.
- The first event is accepted no earlier than the second rising edge after reset deasserts.

## Configuration
- CALC_BCD_OUT_EN defined:
  - Adds outputs bcd (4·(DIGITS+1) bits, magnitude of disp_val), bcd_neg (1 bit) and bcd_valid (1 bit).
  - Produced by a sequential shift-add-3 converter.
  - Conversion start: the cycle after any change of disp_val, latching |disp_val|.
  - Runs WIDTH shift cycles, then updates bcd and bcd_neg and raises bcd_valid. This is WIDTH+2 cycles after disp_val changes.
  - bcd_valid drops in the cycle after disp_val changes. A change mid-conversion restarts the conversion.
  - Reset: bcd = 0, bcd_neg = 0, bcd_valid = 1.
- CALC_BCD_OUT_EN undefined: these ports and the converter do not exist. Behaviour is otherwise identical.

## Test plan
- Keys 1,2,+,3,4,= → disp_val 46, result_valid one pulse, state 3, ovf 0.
- Keys 5,−,9,= → disp_val −4 (0xFFFC). With CALC_BCD_OUT_EN: bcd 0x00004, bcd_neg 1, bcd_valid after 18 cycles.
- Keys 1,2,3,4,5 → disp_val 1234, entry_full 1; the fifth digit is ignored.
- Chain 9999,+,9999,+,9999,+,9999,= → disp_val 32767, ovf 1. Then digit 7 → disp_val 7, ovf 0, state 0.
- Key 8 with btn_pressed held for 1000 cycles → exactly one append (disp_val 8). Op_val 3 event → no state change.
- Keys 4,+,6, then reset asserted asynchronously mid-cycle → all outputs at reset values immediately. Next key 2 → disp_val 2.
